vend_credit_ctrl: RTL and testbench

Credit-tracking controller for the vending machine. Accepts coin pulses, holds credit (0..8 units), runs the dispense handshake, and pays out change one unit at a time. Its registered credit output drives the 4-to-9 credit display decoder directly, as credit[3]..credit[0] mapped to X3..X0. The value never exceeds 8, so exactly one decoder line is always lit.

---
 rtl/vend_credit_ctrl_pkg.sv | 20 ++
 rtl/vend_credit_ctrl_if.sv | 27 ++
 rtl/vend_credit_ctrl_timer.sv | 24 ++
 rtl/vend_credit_ctrl.sv | 131 +++++++++++++
 tb/tb_vend_credit_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vend_credit_ctrl_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DISPENSE, REFUND} state_t;

  localparam int CREDIT_W  = 4;
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;

  typedef logic [CREDIT_W-1:0] credit_t;

  // The timer counts 0..timeout-1, so it needs clog2(timeout) bits (at least 1).
  function automatic int tmr_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int VEND_TIMEOUT_DEF = 15;
  localparam int TMR_W            = tmr_width(VEND_TIMEOUT_DEF);

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Customer/dispenser-facing signal bundle of the credit controller.
interface vend_credit_ctrl_if;
  import vend_pkg::*;

  logic    coin_1;
  logic    coin_2;
  logic    select;
  logic    cancel;
  logic    disp_ack;
  credit_t credit;
  logic    disp_req;
  logic    change_pulse;
  logic    coin_reject;
  logic    vend_fault;
  logic    busy;

  modport master (
    output coin_1, coin_2, select, cancel, disp_ack,
    input  credit, disp_req, change_pulse, coin_reject, vend_fault, busy
  );

  modport slave (
    input  coin_1, coin_2, select, cancel, disp_ack,
    output credit, disp_req, change_pulse, coin_reject, vend_fault, busy
  );

endinterface

// File: rtl/vend_credit_ctrl_timer.sv
// Clear/enable up-counter with a terminal-count flag; holds at terminal count.
module vend_timer #(
  parameter int LIMIT = 15,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(LIMIT - 1));

  // Count while enabled; stop at terminal count so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         count <= '0;
    else if (clr)       count <= '0;
    else if (en && !tc) count <= count + W'(1);
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: coin accumulation, dispense handshake with
// timeout, and unit-by-unit change payout. All outputs are registered.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE        = 6,
  parameter int MAX_CREDIT   = 8,
  parameter int VEND_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  vend_credit_ctrl_if.slave bus
);

  localparam int TW = tmr_width(VEND_TIMEOUT);

  state_t  state_q, state_d;
  credit_t credit_q, credit_d;
  logic    disp_req_d, change_d, reject_d, fault_d, busy_d;

  logic    coin_any, coin_fits;
  credit_t coin_add, coin_sum;
  logic    cancel_acc, select_acc;
  logic    tmr_tc, tmr_en;

  // Both coins in one cycle add 3; a 4-bit sum of at most 11 cannot wrap.
  assign coin_any  = bus.coin_1 | bus.coin_2;
  assign coin_add  = (bus.coin_1 ? credit_t'(COIN1_VAL) : '0)
                   + (bus.coin_2 ? credit_t'(COIN2_VAL) : '0);
  assign coin_sum  = credit_q + coin_add;
  assign coin_fits = (coin_sum <= credit_t'(MAX_CREDIT));

  // Cancel outranks select; a select that is not accepted leaves coins alone.
  assign cancel_acc = (state_q == ACCUM) && bus.cancel;
  assign select_acc = (state_q == ACCUM) && !bus.cancel && bus.select
                    && (credit_q >= credit_t'(PRICE));

  // Timer only runs in DISPENSE; it is held at zero everywhere else so each
  // vend starts counting from 0. disp_req stays up for VEND_TIMEOUT cycles.
  assign tmr_en = (state_q == DISPENSE);

  vend_timer #(.LIMIT(VEND_TIMEOUT), .W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!tmr_en),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (coin_any && coin_fits) state_d = ACCUM;
      ACCUM: begin
        if (cancel_acc)      state_d = REFUND;
        else if (select_acc) state_d = DISPENSE;
      end
      DISPENSE: begin
        if (bus.disp_ack)    state_d = (credit_q != '0) ? REFUND : IDLE;
        else if (tmr_tc)     state_d = REFUND;
      end
      REFUND:   if (credit_q <= credit_t'(1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of credit and of every registered output.
  always_comb begin
    credit_d   = credit_q;
    change_d   = 1'b0;
    reject_d   = 1'b0;
    fault_d    = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (cancel_acc || select_acc) begin
          reject_d = coin_any;
          if (select_acc) credit_d = credit_q - credit_t'(PRICE);
        end else if (coin_any) begin
          if (coin_fits) credit_d = coin_sum;
          else           reject_d = 1'b1;
        end
      end
      DISPENSE: begin
        reject_d = coin_any;
        if (!bus.disp_ack && tmr_tc) begin
          credit_d = credit_q + credit_t'(PRICE);
          fault_d  = 1'b1;
        end
      end
      REFUND: begin
        reject_d = coin_any;
        if (credit_q != '0) begin
          credit_d = credit_q - credit_t'(1);
          change_d = 1'b1;
        end
      end
      default: ;
    endcase
    disp_req_d = (state_d == DISPENSE);
    busy_d     = (state_d == DISPENSE) || (state_d == REFUND);
  end

  // Output and credit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q         <= '0;
      bus.disp_req     <= 1'b0;
      bus.change_pulse <= 1'b0;
      bus.coin_reject  <= 1'b0;
      bus.vend_fault   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      credit_q         <= credit_d;
      bus.disp_req     <= disp_req_d;
      bus.change_pulse <= change_d;
      bus.coin_reject  <= reject_d;
      bus.vend_fault   <= fault_d;
      bus.busy         <= busy_d;
    end
  end

  assign bus.credit = credit_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: directed scenarios then random traffic,
// checked every cycle against a behavioural model of the credit rules.
module tb_vend_credit_ctrl;

  localparam int PRICE        = 6;
  localparam int MAX_CREDIT   = 8;
  localparam int VEND_TIMEOUT = 15;

  typedef struct packed {
    logic [3:0] credit;
    logic       disp_req;
    logic       change;
    logic       reject;
    logic       fault;
    logic       busy;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  logic clk;
  logic rst_n;
  vend_credit_ctrl_if vif();

  vend_credit_ctrl #(
    .PRICE        (PRICE),
    .MAX_CREDIT   (MAX_CREDIT),
    .VEND_TIMEOUT (VEND_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  // Model: credit in units plus "vending" / "paying change" flags and the
  // number of unacknowledged cycles spent waiting on the dispenser.
  int m_credit;
  bit m_vending;
  bit m_paying;
  int m_waited;

  function automatic obs_t observe();
    obs_t o;
    o.credit   = vif.credit;
    o.disp_req = vif.disp_req;
    o.change   = vif.change_pulse;
    o.reject   = vif.coin_reject;
    o.fault    = vif.vend_fault;
    o.busy     = vif.busy;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got credit=%0d req=%b chg=%b rej=%b flt=%b busy=%b, want credit=%0d req=%b chg=%b rej=%b flt=%b busy=%b",
                  tag, act.credit, act.disp_req, act.change, act.reject, act.fault, act.busy,
                  exp.credit, exp.disp_req, exp.change, exp.reject, exp.fault, exp.busy);
  endtask

  function automatic void model_reset();
    m_credit  = 0;
    m_vending = 0;
    m_paying  = 0;
    m_waited  = 0;
  endfunction

  function automatic obs_t model_step(input bit c1, c2, sel, can, ack);
    obs_t e;
    int   add;
    e   = '0;
    add = int'(c1) + 2 * int'(c2);
    if (m_paying) begin
      e.reject = (add > 0);
      e.change = 1'b1;
      m_credit--;
      if (m_credit == 0) m_paying = 0;
    end else if (m_vending) begin
      e.reject = (add > 0);
      if (ack) begin
        m_vending = 0;
        m_paying  = (m_credit > 0);
      end else begin
        m_waited++;
        if (m_waited == VEND_TIMEOUT) begin
          m_credit += PRICE;
          m_vending = 0;
          m_paying  = 1;
          e.fault   = 1'b1;
        end
      end
    end else if (can && m_credit > 0) begin
      m_paying = 1;
      e.reject = (add > 0);
    end else if (sel && m_credit >= PRICE) begin
      m_credit -= PRICE;
      m_vending = 1;
      m_waited  = 0;
      e.reject  = (add > 0);
    end else if (m_credit + add <= MAX_CREDIT) begin
      m_credit += add;
    end else begin
      e.reject = 1'b1;
    end
    e.credit   = 4'(m_credit);
    e.disp_req = m_vending;
    e.busy     = m_vending || m_paying;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the response the model predicts.
  task automatic cycle(input bit c1, c2, sel, can, ack, input string tag);
    exp_t it;
    @(negedge clk);
    vif.coin_1   = c1;
    vif.coin_2   = c2;
    vif.select   = sel;
    vif.cancel   = can;
    vif.disp_ack = ack;
    it.o   = model_step(c1, c2, sel, can, ack);
    it.tag = tag;
    exp_q.push_back(it);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, tag);
  endtask

  // Monitor: outputs are registered, so each queued response is due just
  // after the next rising edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check(it.tag, observe(), it.o);
      end
    end
  end

  initial begin
    int ack_pct;
    vif.coin_1 = 0; vif.coin_2 = 0; vif.select = 0; vif.cancel = 0; vif.disp_ack = 0;
    model_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #2 check("reset_state", observe(), obs_t'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Three 2-unit coins, buy, immediate ack: no change owed.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, "coin2_accum");
    cycle(0, 0, 1, 0, 0, "select_exact");
    cycle(0, 0, 0, 0, 1, "ack_no_change");
    idle(2, "idle_after_vend");

    // Overflow rejection at 7, then fill to 8 and buy with a late ack.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, "fill");
    cycle(1, 0, 0, 0, 0, "fill_7");
    cycle(0, 1, 0, 0, 0, "overflow_reject");
    cycle(1, 0, 0, 0, 0, "fill_8");
    cycle(0, 0, 1, 0, 0, "select_at_8");
    idle(3, "await_ack");
    cycle(0, 0, 0, 0, 1, "late_ack");
    idle(4, "change_2");

    // Dispenser never acknowledges: fault, restore, refund everything.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, "fill_6");
    cycle(0, 0, 1, 0, 0, "select_timeout");
    idle(VEND_TIMEOUT + 8, "timeout_refund");

    // Cancel beats select, coin in the same cycle is rejected.
    cycle(0, 1, 0, 0, 0, "fill_5");
    cycle(0, 1, 0, 0, 0, "fill_5");
    cycle(1, 0, 0, 0, 0, "fill_5");
    cycle(1, 0, 1, 1, 0, "cancel_select_coin");
    idle(7, "refund_5");
    cycle(1, 1, 0, 0, 0, "both_coins");
    cycle(0, 0, 1, 0, 0, "select_short");
    cycle(0, 0, 0, 1, 0, "cancel_3");
    idle(5, "refund_3");

    // Reset during refund once credit has counted down to 3.
    cycle(0, 1, 0, 0, 0, "fill_r");
    cycle(0, 1, 0, 0, 0, "fill_r");
    cycle(1, 0, 0, 0, 0, "fill_r");
    cycle(0, 0, 0, 1, 0, "cancel_r");
    idle(2, "refund_to_3");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_mid_refund", observe(), obs_t'(0));
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, "coin_after_reset");
    idle(2, "post_reset");

    // Random traffic; ack-free stretches make timeouts happen regularly.
    ack_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 0 : 30;
      cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < ack_pct, "random");
    end

    @(negedge clk);
    vif.coin_1 = 0; vif.coin_2 = 0; vif.select = 0; vif.cancel = 0; vif.disp_ack = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d responses still pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
